// File: rtl/smu_bus_pkg.sv
// rtl/smu_bus_pkg.sv - shared state encoding and default address map for the SMU data bus fabric
package smu_bus_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } bus_state_t;

   localparam logic [31:0] DMEM_BASE     = 32'h1000_0000;
   localparam logic [31:0] DMEM_MASK     = 32'hFFFF_C000;
   localparam logic [31:0] TBMAN_BASE    = 32'h8000_0000;
   localparam logic [31:0] TBMAN_MASK    = 32'hFFFF_0000;
   localparam logic [31:0] ERR_RDATA_DEF = 32'hDEAD_BEEF;
   localparam logic [7:0]  ERR_CNT_MAX   = 8'hFF;

endpackage

// File: rtl/smu_addr_match.sv
// rtl/smu_addr_match.sv - combinational base/mask decoder, one-hot match with lowest-index priority
module smu_addr_match
   import smu_bus_pkg::*;
#(
   parameter int                     NSLV     = 2,
   parameter int                     AWIDTH   = 32,
   parameter logic [NSLV*AWIDTH-1:0] SLV_BASE = {TBMAN_BASE, DMEM_BASE},
   parameter logic [NSLV*AWIDTH-1:0] SLV_MASK = {TBMAN_MASK, DMEM_MASK}
) (
   input  logic [AWIDTH-1:0] addr,
   output logic [NSLV-1:0]   match,
   output logic              hit
);

   // Scan from the top so the lowest matching index is the last one written.
   always_comb begin
      match = '0;
      hit   = 1'b0;
      for (int i = NSLV - 1; i >= 0; i--) begin
         if ((addr & SLV_MASK[i*AWIDTH +: AWIDTH]) == SLV_BASE[i*AWIDTH +: AWIDTH]) begin
            match    = '0;
            match[i] = 1'b1;
            hit      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/smu_bus_fabric.sv
// rtl/smu_bus_fabric.sv - registered request/response data bus fabric with wait states, timeout and bus errors
module smu_bus_fabric
   import smu_bus_pkg::*;
#(
   parameter int                     NSLV      = 2,
   parameter int                     AWIDTH    = 32,
   parameter int                     DWIDTH    = 32,
   parameter int                     TIMEOUT   = 16,
   parameter logic [NSLV*AWIDTH-1:0] SLV_BASE  = {TBMAN_BASE, DMEM_BASE},
   parameter logic [NSLV*AWIDTH-1:0] SLV_MASK  = {TBMAN_MASK, DMEM_MASK},
   parameter logic [DWIDTH-1:0]      ERR_RDATA = ERR_RDATA_DEF
) (
   input  logic                     clk,
   input  logic                     n_rst,
   input  logic                     m_req,
   input  logic                     m_we,
   input  logic [AWIDTH-1:0]        m_addr,
   input  logic [DWIDTH/8-1:0]      m_be,
   input  logic [DWIDTH-1:0]        m_wdata,
   output logic [DWIDTH-1:0]        m_rdata,
   output logic                     m_ready,
   output logic                     m_err,
   output logic [NSLV-1:0]          s_sel,
   output logic                     s_we,
   output logic [AWIDTH-1:0]        s_addr,
   output logic [DWIDTH/8-1:0]      s_be,
   output logic [DWIDTH-1:0]        s_wdata,
   input  logic [NSLV*DWIDTH-1:0]   s_rdata,
   input  logic [NSLV-1:0]          s_ready,
   output logic [AWIDTH-1:0]        err_addr,
   output logic [7:0]               err_cnt
);

   localparam logic [7:0] TO_LIM = 8'(TIMEOUT - 1);

   bus_state_t          state, state_nxt;
   logic [NSLV-1:0]     match;
   logic                hit;
   logic [7:0]          to_cnt;
   logic                sel_ready;
   logic [DWIDTH-1:0]   sel_rdata;
   logic                latch_req, decode_err, acc_ok, acc_to;

   smu_addr_match #(
      .NSLV     (NSLV),
      .AWIDTH   (AWIDTH),
      .SLV_BASE (SLV_BASE),
      .SLV_MASK (SLV_MASK)
   ) u_match (
      .addr  (m_addr),
      .match (match),
      .hit   (hit)
   );

   // Only the selected slave's handshake and data are ever looked at.
   assign sel_ready = |(s_sel & s_ready);

   always_comb begin
      sel_rdata = '0;
      for (int i = 0; i < NSLV; i++) begin
         if (s_sel[i]) begin
            sel_rdata = s_rdata[i*DWIDTH +: DWIDTH];
         end
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      latch_req  = 1'b0;
      decode_err = 1'b0;
      acc_ok     = 1'b0;
      acc_to     = 1'b0;
      case (state)
         IDLE: begin
            if (m_req) begin
               latch_req  = 1'b1;
               decode_err = !hit;
               state_nxt  = hit ? ACCESS : RESP;
            end
         end
         ACCESS: begin
            // A ready in the limit cycle still wins over the timeout.
            if (sel_ready) begin
               acc_ok    = 1'b1;
               state_nxt = RESP;
            end else if (to_cnt == TO_LIM) begin
               acc_to    = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         s_sel    <= '0;
         s_we     <= 1'b0;
         s_addr   <= '0;
         s_be     <= '0;
         s_wdata  <= '0;
         to_cnt   <= '0;
      end else begin
         if (latch_req) begin
            s_sel   <= match;
            s_we    <= m_we;
            s_addr  <= m_addr;
            s_be    <= m_be;
            s_wdata <= m_wdata;
         end else if (acc_ok || acc_to) begin
            s_sel <= '0;
         end
         if (state == ACCESS && !sel_ready) begin
            to_cnt <= to_cnt + 8'd1;
         end else begin
            to_cnt <= '0;
         end
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         m_ready  <= 1'b0;
         m_err    <= 1'b0;
         m_rdata  <= '0;
         err_addr <= '0;
         err_cnt  <= '0;
      end else begin
         m_ready <= (state_nxt == RESP);
         if (acc_ok) begin
            m_rdata <= s_we ? '0 : sel_rdata;
            m_err   <= 1'b0;
         end else if (acc_to || decode_err) begin
            m_rdata <= ERR_RDATA;
            m_err   <= 1'b1;
         end else if (state == RESP) begin
            m_err <= 1'b0;
         end
         if (state == RESP && m_err) begin
            err_addr <= s_addr;
            err_cnt  <= (err_cnt == ERR_CNT_MAX) ? err_cnt : err_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_smu_bus_fabric.sv
// tb/tb_smu_bus_fabric.sv - scoreboard bench for smu_bus_fabric against a range-based reference model
module tb_smu_bus_fabric;

   localparam int          TIMEOUT = 16;
   localparam logic [31:0] ERR_VAL = 32'hDEAD_BEEF;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        n_rst = 1'b0;
   logic        m_req = 1'b0;
   logic        m_we = 1'b0;
   logic [31:0] m_addr = '0;
   logic [3:0]  m_be = '0;
   logic [31:0] m_wdata = '0;
   logic [31:0] m_rdata;
   logic        m_ready, m_err;
   logic [1:0]  s_sel;
   logic        s_we;
   logic [31:0] s_addr;
   logic [3:0]  s_be;
   logic [31:0] s_wdata;
   logic [63:0] s_rdata = '0;
   logic [1:0]  s_ready = '0;
   logic [31:0] err_addr;
   logic [7:0]  err_cnt;

   logic        ov_req = 1'b0;
   logic [31:0] ov_m_rdata;
   logic        ov_m_ready, ov_m_err;
   logic [1:0]  ov_s_sel;
   logic        ov_s_we;
   logic [31:0] ov_s_addr;
   logic [3:0]  ov_s_be;
   logic [31:0] ov_s_wdata;
   logic [63:0] ov_s_rdata = {32'hBBBB_BBBB, 32'hAAAA_AAAA};
   logic [1:0]  ov_s_ready = 2'b11;
   logic [31:0] ov_err_addr;
   logic [7:0]  ov_err_cnt;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   exp_t        exp_q[$];
   int          wait_cfg[2];
   int          acc_cnt[2];
   logic [1:0]  exp_sel = '0;
   logic        cur_we = 1'b0;
   logic [31:0] cur_addr = '0;
   logic [3:0]  cur_be = '0;
   logic [31:0] cur_wdata = '0;
   int          exp_err_cnt = 0;
   logic [31:0] exp_err_addr = '0;

   smu_bus_fabric #(.TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .n_rst(n_rst), .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
      .m_be(m_be), .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ready(m_ready),
      .m_err(m_err), .s_sel(s_sel), .s_we(s_we), .s_addr(s_addr), .s_be(s_be),
      .s_wdata(s_wdata), .s_rdata(s_rdata), .s_ready(s_ready),
      .err_addr(err_addr), .err_cnt(err_cnt)
   );

   smu_bus_fabric #(
      .TIMEOUT  (TIMEOUT),
      .SLV_BASE ({32'h1000_0000, 32'h1000_0000}),
      .SLV_MASK ({32'hFFFF_C000, 32'hFFFF_C000})
   ) dut_ov (
      .clk(clk), .n_rst(n_rst), .m_req(ov_req), .m_we(m_we), .m_addr(m_addr),
      .m_be(m_be), .m_wdata(m_wdata), .m_rdata(ov_m_rdata), .m_ready(ov_m_ready),
      .m_err(ov_m_err), .s_sel(ov_s_sel), .s_we(ov_s_we), .s_addr(ov_s_addr),
      .s_be(ov_s_be), .s_wdata(ov_s_wdata), .s_rdata(ov_s_rdata), .s_ready(ov_s_ready),
      .err_addr(ov_err_addr), .err_cnt(ov_err_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   function automatic int ref_slave(input logic [31:0] a);
      if (a >= 32'h1000_0000 && a <= 32'h1000_3FFF) return 0;
      if (a >= 32'h8000_0000 && a <= 32'h8000_FFFF) return 1;
      return -1;
   endfunction

   // Slave model: selected slave answers after wait_cfg cycles, idle slaves toggle ready at random.
   initial begin
      acc_cnt[0] = 0; acc_cnt[1] = 0;
      wait_cfg[0] = 0; wait_cfg[1] = 0;
      forever begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            if (s_sel[i]) begin
               s_ready[i] = (acc_cnt[i] == wait_cfg[i]);
               acc_cnt[i]++;
            end else begin
               s_ready[i] = 1'($urandom_range(0, 1));
               acc_cnt[i] = 0;
            end
         end
      end
   end

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (n_rst) begin
            if (s_sel != 2'b00) begin
               chk("sel", 64'(s_sel), 64'(exp_sel));
               chk("hold_addr", 64'(s_addr), 64'(cur_addr));
               chk("hold_ctl", 64'({s_we, s_be, s_wdata}), 64'({cur_we, cur_be, cur_wdata}));
            end
            if (m_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_resp: got m_ready=1 expected no response");
               end else begin
                  e = exp_q.pop_front();
                  chk("rdata", 64'(m_rdata), 64'(e.rdata));
                  chk("err", 64'(m_err), 64'(e.err));
                  chk("latency", 64'(cyc), 64'(e.cyc));
               end
            end
         end
      end
   end

   task automatic do_txn(input logic we, input logic [31:0] addr, input logic [3:0] be, input int wt);
      int          sl, lat, n;
      exp_t        e;
      logic [31:0] rd0, rd1;
      sl  = ref_slave(addr);
      rd0 = $urandom;
      rd1 = $urandom;
      s_rdata     = {rd1, rd0};
      wait_cfg[0] = wt;
      wait_cfg[1] = wt;
      m_we    = we;
      m_addr  = addr;
      m_be    = be;
      m_wdata = $urandom;
      cur_we = we; cur_addr = addr; cur_be = be; cur_wdata = m_wdata;
      exp_sel = (sl < 0) ? 2'b00 : 2'(1 << sl);
      if (sl < 0) begin
         e.err = 1'b1; e.rdata = ERR_VAL; lat = 1;
      end else if (wt >= TIMEOUT) begin
         e.err = 1'b1; e.rdata = ERR_VAL; lat = 1 + TIMEOUT;
      end else begin
         e.err = 1'b0; e.rdata = we ? 32'h0 : ((sl == 0) ? rd0 : rd1); lat = 2 + wt;
      end
      e.cyc = cyc + lat;
      if (e.err) begin
         exp_err_addr = addr;
         if (exp_err_cnt < 255) exp_err_cnt++;
      end
      exp_q.push_back(e);
      m_req = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!m_ready && n < 300);
      if (!m_ready) begin
         checks++;
         errors++;
         $display("FAIL resp_timeout: got no m_ready expected one within 300 cycles");
         exp_q.delete();
      end
      m_req = 1'b0;
      @(negedge clk);
      chk("err_cnt", 64'(err_cnt), 64'(exp_err_cnt));
      chk("err_addr", 64'(err_addr), 64'(exp_err_addr));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      int          kind;
      repeat (3) @(negedge clk);
      chk("rst_sel", 64'(s_sel), 64'h0);
      chk("rst_ready", 64'({m_ready, m_err, s_we, s_be}), 64'h0);
      chk("rst_addr", 64'(s_addr), 64'h0);
      chk("rst_rdata", 64'(m_rdata), 64'h0);
      chk("rst_errlog", 64'({err_addr, err_cnt}), 64'h0);
      n_rst = 1'b1;
      @(negedge clk);

      m_we = 1'b0; m_addr = 32'h1000_0000; ov_req = 1'b1;
      @(negedge clk);
      chk("ov_sel", 64'(ov_s_sel), 64'h1);
      @(negedge clk);
      chk("ov_resp", 64'({ov_m_ready, ov_m_err, ov_m_rdata}), 64'({1'b1, 1'b0, 32'hAAAA_AAAA}));
      ov_req = 1'b0;
      @(negedge clk);

      do_txn(1'b0, 32'h1000_0010, 4'hF, 0);
      do_txn(1'b1, 32'h8000_0004, 4'b0011, 3);
      do_txn(1'b0, 32'h4000_0000, 4'hF, 0);
      do_txn(1'b0, 32'h1000_0020, 4'hF, 255);
      do_txn(1'b0, 32'h1000_0024, 4'hF, TIMEOUT - 1);
      do_txn(1'b1, 32'h8000_0100, 4'hF, TIMEOUT);
      do_txn(1'b1, 32'h2000_0000, 4'hF, 0);

      for (int i = 0; i < 60; i++) begin
         kind = $urandom_range(0, 3);
         case (kind)
            0:       a = 32'h1000_0000 | ($urandom & 32'h3FFC);
            1:       a = 32'h8000_0000 | ($urandom & 32'hFFFC);
            2:       a = 32'h4000_0000 | ($urandom & 32'hFFFF);
            default: a = $urandom;
         endcase
         do_txn(1'($urandom_range(0, 1)), a, 4'($urandom), $urandom_range(0, TIMEOUT + 2));
      end

      // Reset in the middle of an access to a slave that never answers.
      wait_cfg[0] = 255;
      m_we = 1'b0; m_addr = 32'h1000_0100; m_be = 4'hF;
      cur_we = 1'b0; cur_addr = m_addr; cur_be = 4'hF; cur_wdata = m_wdata;
      exp_sel = 2'b01;
      m_req = 1'b1;
      repeat (3) @(negedge clk);
      #2 n_rst = 1'b0;
      #1;
      chk("rst_mid_sel", 64'(s_sel), 64'h0);
      chk("rst_mid_ready", 64'(m_ready), 64'h0);
      m_req = 1'b0;
      exp_q.delete();
      exp_err_cnt = 0;
      exp_err_addr = '0;
      @(negedge clk);
      #2 n_rst = 1'b1;
      repeat (4) @(negedge clk);
      chk("rst_mid_errcnt", 64'(err_cnt), 64'h0);
      do_txn(1'b0, 32'h1000_0200, 4'hF, 1);

      for (int i = 0; i < 260; i++) begin
         do_txn(1'b0, 32'h4000_0000 + 32'(i * 4), 4'hF, 0);
      end
      chk("err_cnt_sat", 64'(err_cnt), 64'd255);
      chk("queue_empty", 64'(exp_q.size()), 64'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/smu_bus_fabric.md
# smu_bus_fabric

Parametrised data-side bus fabric for the SMU RV32I system. It sits between the CPU data port and NSLV memory-mapped slaves (DMEM, testbench manager, timer, UART, ...). It replaces the fixed two-way decoder and read-data mux with a registered request/response transaction engine. Each slave gets a select and a ready handshake, so a slave can insert wait states. Unmapped or unresponsive accesses end with a bus error instead of hanging the core.

## Interface
Parameters:
- NSLV, 2: number of slave ports (1..8)
- AWIDTH, 32: address width
- DWIDTH, 32: data width (multiple of 8)
- TIMEOUT, 16: maximum ACCESS cycles before a timeout error (2..255)
- SLV_BASE, {32'h8000_0000, 32'h1000_0000}: packed NSLV×AWIDTH base addresses, slave 0 in the LSBs
- SLV_MASK, {32'hFFFF_0000, 32'hFFFF_C000}: packed NSLV×AWIDTH compare masks
- ERR_RDATA, 32'hDEAD_BEEF: read data returned on an error

Ports:
- clk  in  1  system clock, rising edge
- n_rst  in  1  asynchronous, active-low reset
- m_req  in  1  master request; held with all m_* signals until m_ready
- m_we  in  1  1 = write, 0 = read
- m_addr  in  AWIDTH  byte address
- m_be  in  DWIDTH/8  byte enables
- m_wdata  in  DWIDTH  write data, byte-lane aligned
- m_rdata  out  DWIDTH  registered read data, valid while m_ready
- m_ready  out  1  one-cycle completion pulse
- m_err  out  1  error flag, valid with m_ready
- s_sel  out  NSLV  one-hot slave select
- s_we, s_addr, s_be, s_wdata  out  1/AWIDTH/DWIDTH/8/DWIDTH  latched request fields broadcast to all slaves
- s_rdata  in  NSLV×DWIDTH  packed slave read data
- s_ready  in  NSLV  slave completion; sampled only for the selected slave
- err_addr  out  AWIDTH  address of the most recent errored access (sticky)
- err_cnt  out  8  saturating error count

## Operation
Decode:
- Slave i matches when (m_addr & SLV_MASK[i]) == SLV_BASE[i].
- If several slaves match, the lowest index wins.
- No match means a decode error.

The FSM has three states: IDLE, ACCESS and RESP.

IDLE:
- m_req=1 latches m_we, m_addr, m_be and m_wdata into the s_* registers.
- On a match: s_sel[i] is set and the FSM moves to ACCESS.
- On no match: the FSM moves directly to RESP with err=1. No s_sel is asserted, so an unmapped write has no side effect.

ACCESS:
- s_sel stays held.
- If s_ready[i]=1: capture s_rdata[i] (reads) into m_rdata, clear s_sel, and move to RESP with err=0.
- Otherwise the timeout counter increments.
- If the counter reaches TIMEOUT-1 with s_ready low: clear s_sel, set m_rdata = ERR_RDATA and move to RESP with err=1.

RESP:
- m_ready=1 for exactly one cycle, with m_err set per the result.
- On error: err_addr takes the latched address, and err_cnt increments, saturating at 255.
- Next state is always IDLE.
- m_req is not sampled in RESP. The master drops or changes its request after seeing m_ready.

Read data:
- m_rdata holds its last value outside RESP.
- For a write, m_rdata is 0.
- For an error, m_rdata is ERR_RDATA, whether the access was a read or a write.

Hold behaviour:
- s_we, s_addr, s_be and s_wdata are stable for the whole ACCESS state.
- A write is committed by the slave in a cycle where s_sel[i] & s_we & s_ready[i] are all 1.

## Timing
Reset values (n_rst=0, asynchronous):
- State: IDLE.
- s_sel, m_ready, m_err, s_we, s_be: 0.
- s_addr, s_wdata, m_rdata, err_addr, err_cnt: 0.
- The timeout counter is cleared.

Latency, with request sampled at cycle 0:
- Zero-wait slave: s_sel high at cycle 1, m_ready at cycle 2. Throughput is one transaction per 3 cycles.
- Each slave wait cycle adds 1 cycle.
- Decode error: m_ready at cycle 1.
- Timeout: m_ready at cycle 1+TIMEOUT.

Boundary cases:
- s_ready from a non-selected slave is ignored.
- s_ready arriving in the same cycle as the timeout limit completes normally (err=0).
- Reset asserted during ACCESS drops s_sel immediately. No response is generated after reset releases.
- err_cnt at 255 stays at 255.

## Structure
- A shared package smu_bus_pkg holds:
  - the FSM state encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2);
  - the default DMEM and TBMAN base/mask constants;
  - ERR_RDATA.
- One sub-module, smu_addr_match: a combinational parametrised decoder that produces the one-hot match vector with lowest-index priority and a hit flag.
- The FSM, latches, timeout counter and error logs live in smu_bus_fabric.

## Test plan
- **DMEM zero-wait read:** read m_addr=0x1000_0010, slave 0 s_ready=1 with s_rdata=0x1234_5678 → s_sel=01 at cycle 1; m_ready=1, m_err=0, m_rdata=0x1234_5678 at cycle 2.
- **TBMAN write with wait states:** write m_addr=0x8000_0004, m_be=4'b0011; s_ready[1] asserted after 3 wait cycles → s_sel=10 for 4 cycles with s_wdata/s_be held stable; m_ready at cycle 5 with m_err=0.
- **Unmapped read:** read m_addr=0x4000_0000 → s_sel stays 00; m_ready at cycle 1 with m_err=1, m_rdata=0xDEAD_BEEF; err_addr=0x4000_0000, err_cnt=1.
- **Timeout:** slave 0 never readies, TIMEOUT=16 → s_sel deasserted and m_ready with m_err=1 at cycle 17; err_cnt increments.
- **Reset mid-access:** n_rst pulsed low during ACCESS → s_sel=0 and m_ready=0 asynchronously; state is IDLE after release; a new request completes normally.
- **Overlap priority and saturation:** both slaves configured to match 0x1000_0000 → slave 0 is selected. Then 260 unmapped accesses → err_cnt=255.
